// File: rtl/fp_pkg.sv
// Shared format helpers, flag indices and stage-register control type for the FP add/sub pipeline.
package fp_pkg;

    localparam int unsigned DEF_EXP_W = 8;
    localparam int unsigned DEF_MAN_W = 23;
    localparam int unsigned DEF_TAG_W = 4;

    localparam int unsigned FLG_INVALID   = 3;
    localparam int unsigned FLG_OVERFLOW  = 2;
    localparam int unsigned FLG_UNDERFLOW = 1;
    localparam int unsigned FLG_INEXACT   = 0;

    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned fp_exp_max(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

    // Quiet NaN: sign 0, exponent all ones, mantissa MSB set.
    function automatic logic [63:0] canon_nan(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] e_ones;
        e_ones = (64'd1 << exp_w) - 64'd1;
        return (e_ones << man_w) | (64'd1 << (man_w - 1));
    endfunction

    typedef struct packed {
        logic       valid;
        logic       sign;
        logic       eff_sub;
        logic       special;
        logic [3:0] flags;
    } stage_ctl_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero count with an all-zero indication.
module fp_lzc
    import fp_pkg::*;
#(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count,
    output logic             all_zero
);

    // Highest set bit wins since the scan runs LSB to MSB.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (value[i]) begin
                count = CNT_W'(int'(WIDTH) - 1 - i);
            end
        end
    end

    assign all_zero = ~|value;

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor: align, add, normalise/round/pack; valid/ready with global stall.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter  int unsigned EXP_W = DEF_EXP_W,
    parameter  int unsigned MAN_W = DEF_MAN_W,
    parameter  int unsigned TAG_W = DEF_TAG_W,
    localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags
);

    localparam int unsigned XW   = MAN_W + 4;   // {hidden, mantissa, G, R, S}
    localparam int unsigned SW   = MAN_W + 5;   // aligned sum including carry
    localparam int unsigned SH_W = $clog2(XW);
    localparam int unsigned LZ_W = $clog2(XW + 1);
    localparam int unsigned EW   = EXP_W + 2;   // signed headroom for exponent adjust
    localparam logic [W-1:0]     QNAN      = W'(canon_nan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] EXP_ONES  = EXP_W'(fp_exp_max(EXP_W));
    localparam logic [EXP_W:0]   EXP_MAX_X = (EXP_W + 1)'(fp_exp_max(EXP_W));

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance & ~rst;

    // S1: unpack, flush subnormals, classify specials, swap and align
    logic             sa, sb, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_ge;
    logic [EXP_W-1:0] ea, eb, ex, ey, diff;
    logic [MAN_W-1:0] ma, mb;
    logic [XW-1:0]    mx, my, my_sh;
    logic [2*XW-1:0]  y_ext;
    logic [SH_W-1:0]  sh;
    stage_ctl_t       c1;
    logic [W-1:0]     r1;

    always_comb begin
        sa     = in_a[W-1];
        sb     = in_b[W-1] ^ in_sub;
        ea     = in_a[W-2 -: EXP_W];
        eb     = in_b[W-2 -: EXP_W];
        ma     = (ea == '0) ? '0 : in_a[MAN_W-1:0];
        mb     = (eb == '0) ? '0 : in_b[MAN_W-1:0];
        a_nan  = (ea == EXP_ONES) && (in_a[MAN_W-1:0] != '0);
        b_nan  = (eb == EXP_ONES) && (in_b[MAN_W-1:0] != '0);
        a_snan = a_nan & ~in_a[MAN_W-1];
        b_snan = b_nan & ~in_b[MAN_W-1];
        a_inf  = (ea == EXP_ONES) && (in_a[MAN_W-1:0] == '0);
        b_inf  = (eb == EXP_ONES) && (in_b[MAN_W-1:0] == '0);

        a_ge       = {ea, ma} >= {eb, mb};
        ex         = a_ge ? ea : eb;
        ey         = a_ge ? eb : ea;
        mx         = a_ge ? {|ea, ma, 3'b000} : {|eb, mb, 3'b000};
        my         = a_ge ? {|eb, mb, 3'b000} : {|ea, ma, 3'b000};
        diff       = ex - ey;
        sh         = (32'(diff) > XW - 1) ? SH_W'(XW - 1) : SH_W'(diff);
        y_ext      = {my, XW'(0)} >> sh;
        my_sh      = {y_ext[2*XW-1:XW+1], y_ext[XW] | (|y_ext[XW-1:0])};

        c1.valid   = in_valid;
        c1.sign    = a_ge ? sa : sb;
        c1.eff_sub = sa ^ sb;
        c1.special = 1'b1;
        c1.flags   = '0;
        r1         = QNAN;
        if (a_nan || b_nan) begin
            c1.flags[FLG_INVALID] = a_snan | b_snan;
        end else if (a_inf && b_inf && (sa != sb)) begin
            c1.flags[FLG_INVALID] = 1'b1;
        end else if (a_inf) begin
            r1 = {sa, EXP_ONES, MAN_W'(0)};
        end else if (b_inf) begin
            r1 = {sb, EXP_ONES, MAN_W'(0)};
        end else begin
            c1.special = 1'b0;
        end
    end

    stage_ctl_t       s1, s2;
    logic [W-1:0]     s1_res, s2_res;
    logic [EXP_W-1:0] s1_exp, s2_exp;
    logic [XW-1:0]    s1_mx, s1_my;
    logic [SW-1:0]    s2_sum, sum;
    logic [TAG_W-1:0] s1_tag, s2_tag;

    // S2: magnitude add/subtract; X is never smaller than aligned Y
    always_comb begin
        sum = s1.eff_sub ? ({1'b0, s1_mx} - {1'b0, s1_my}) : ({1'b0, s1_mx} + {1'b0, s1_my});
    end

    // S3: normalise, round to nearest even, range check, pack
    logic [LZ_W-1:0]  lz;
    logic             sum_zero, carry, rnd_up, inexact, uflow, oflow;
    logic [XW-1:0]    norm;
    logic [EW-1:0]    e_pre, e_fin;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] frac;
    logic [W-1:0]     r3;
    logic [3:0]       f3;

    fp_lzc #(.WIDTH(XW), .CNT_W(LZ_W)) u_lzc (
        .value    (s2_sum[XW-1:0]),
        .count    (lz),
        .all_zero (sum_zero)
    );

    always_comb begin
        carry = s2_sum[SW-1];
        if (carry) begin
            norm  = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
            e_pre = {2'b00, s2_exp} + EW'(1);
        end else begin
            norm  = s2_sum[XW-1:0] << lz;
            e_pre = {2'b00, s2_exp} - EW'(lz);
        end
        rnd_up  = norm[2] & (norm[3] | norm[1] | norm[0]);
        inexact = |norm[2:0];
        mant_r  = {1'b0, norm[XW-1:3]} + (MAN_W + 2)'(rnd_up);
        e_fin   = e_pre + EW'(mant_r[MAN_W+1]);
        frac    = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        uflow   = e_fin[EW-1] | (e_fin == '0);
        oflow   = ~e_fin[EW-1] & (e_fin[EW-2:0] >= EXP_MAX_X);

        r3 = '0;
        f3 = '0;
        if (s2.special) begin
            r3 = s2_res;
            f3 = s2.flags;
        end else if (!carry && sum_zero) begin
            r3 = {s2.sign & ~s2.eff_sub, (W - 1)'(0)};
        end else if (uflow) begin
            r3                = {s2.sign, (W - 1)'(0)};
            f3[FLG_UNDERFLOW] = 1'b1;
            f3[FLG_INEXACT]   = 1'b1;
        end else if (oflow) begin
            r3               = {s2.sign, EXP_ONES, MAN_W'(0)};
            f3[FLG_OVERFLOW] = 1'b1;
            f3[FLG_INEXACT]  = 1'b1;
        end else begin
            r3              = {s2.sign, e_fin[EXP_W-1:0], frac};
            f3[FLG_INEXACT] = inexact;
        end
    end

    // All stages shift together on advance; a stall freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= '0;
            s1_res     <= '0;
            s1_exp     <= '0;
            s1_mx      <= '0;
            s1_my      <= '0;
            s1_tag     <= '0;
            s2         <= '0;
            s2_res     <= '0;
            s2_exp     <= '0;
            s2_sum     <= '0;
            s2_tag     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else if (advance) begin
            s1        <= c1;
            s1_res    <= r1;
            s1_exp    <= ex;
            s1_mx     <= mx;
            s1_my     <= my_sh;
            s1_tag    <= in_tag;
            s2        <= s1;
            s2_res    <= s1_res;
            s2_exp    <= s1_exp;
            s2_sum    <= sum;
            s2_tag    <= s1_tag;
            out_valid <= s2.valid;
            if (s2.valid) begin
                out_result <= r3;
                out_tag    <= s2_tag;
                out_flags  <= f3;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed vectors, backpressure stream and mid-flight reset.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic [3:0]  out_flags;

    fp_addsub_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [3:0]  flags;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          stall_cycles = 0;
    bit          stalled_prev = 1'b0;
    logic [31:0] held_res;
    logic [3:0]  held_tag;

    logic [31:0] va   [15];
    logic [31:0] vb   [15];
    logic        vs   [15];
    logic [31:0] vr   [15];
    logic [3:0]  vf   [15];
    logic [31:0] flt  [10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every transfer against the scoreboard; watch stall behaviour.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!out_ready) begin
                stall_cycles++;
                check("in_ready_stall", 64'(in_ready), 64'(0));
                if (stalled_prev) begin
                    check("hold_result", 64'(out_result), 64'(held_res));
                    check("hold_tag", 64'(out_tag), 64'(held_tag));
                end
                held_res     = out_result;
                held_tag     = out_tag;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %08h tag %0d, expected no output", out_result, out_tag);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("result", 64'(out_result), 64'(mon_e.res));
                    check("tag", 64'(out_tag), 64'(mon_e.tag));
                    check("flags", 64'(out_flags), 64'(mon_e.flags));
                    if (mon_e.due >= 0) check("latency", 64'(cyc), 64'(mon_e.due));
                end
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [3:0] tag,
                        input logic [31:0] res, input logic [3:0] flg, input bit lat);
        int   n;
        exp_t e;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_tag   = tag;
        in_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", n);
        end else begin
            e.res   = res;
            e.tag   = tag;
            e.flags = flg;
            e.due   = lat ? cyc + 3 : -1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        va = '{32'h3FC00000, 32'hC0500000, 32'hBF800000, 32'h3F800000, 32'h3F800001,
               32'h7F7FFFFF, 32'h7F800000, 32'h7FC00000, 32'h00000001, 32'h80000000,
               32'h7F800001, 32'hFF800000, 32'h00800000, 32'h40400000, 32'h3F7FFFFF};
        vb = '{32'h40200000, 32'h3FE00000, 32'hBF800000, 32'h33800000, 32'h33800000,
               32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h00000001, 32'h80000000,
               32'h3F800000, 32'h3F800000, 32'h00C00000, 32'h3F800000, 32'h33000000};
        vs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vr = '{32'h40800000, 32'hBFC00000, 32'h00000000, 32'h3F800000, 32'h3F800002,
               32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h80000000,
               32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h40000000, 32'h3F800000};
        vf = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h5, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h3, 4'h0, 4'h1};
        flt = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_result", 64'(out_result), 64'(0));
        check("reset_out_tag", 64'(out_tag), 64'(0));
        check("reset_out_flags", 64'(out_flags), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Directed vectors, back to back, each with a 3-cycle latency expectation
        for (int i = 0; i < 15; i++) begin
            send(va[i], vb[i], vs[i], 4'(i), vr[i], vf[i], 1'b1);
        end
        idle(6);

        // Backpressure: 8 ops, consumer stalls for 5 cycles mid-stream
        stall_cycles = 0;
        fork
            begin
                for (int t = 0; t < 8; t++) begin
                    send(flt[t + 1], 32'h3F800000, 1'b0, 4'(t), flt[t + 2], 4'h0, 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(12);
        check("stream_drained", 64'(sb_q.size()), 64'(0));
        check("stall_cycles", 64'(stall_cycles), 64'(5));

        // Reset with three operations in flight
        out_ready = 1'b0;
        send(flt[1], flt[1], 1'b0, 4'd8, flt[2], 4'h0, 1'b0);
        send(flt[2], flt[1], 1'b0, 4'd9, flt[3], 4'h0, 1'b0);
        send(flt[3], flt[1], 1'b0, 4'd10, flt[4], 4'h0, 1'b0);
        in_valid = 1'b0;
        check("out_valid_before_reset", 64'(out_valid), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("out_valid_async_reset", 64'(out_valid), 64'(0));
        check("in_ready_in_reset", 64'(in_ready), 64'(0));
        sb_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rerelease", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        idle(5);
        send(flt[4], flt[4], 1'b0, 4'd11, flt[8], 4'h0, 1'b1);
        idle(8);
        check("final_drained", 64'(sb_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
